// File: rtl/bin_select_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bin_select_fifo_pkg
// Shared defaults for the FFT bin-select FIFO: sample/index/frame widths, the
// default kept bin range (lower half of the spectrum including Nyquist), the
// default FIFO depth and the output-stage state encoding.
// -----------------------------------------------------------------------------
package bin_select_fifo_pkg;

  localparam int DEF_I_BW   = 14;
  localparam int DEF_O_BW   = 14;
  localparam int DEF_LOG2_N = 10;
  localparam int DEF_FRM_BW = 7;
  localparam int DEF_N      = 2 ** DEF_LOG2_N;
  localparam int DEF_BIN_LO = 0;
  localparam int DEF_BIN_HI = DEF_N / 2;
  localparam int DEF_DEPTH  = 16;

  // Output head register state: EMPTY presents nothing, VALID presents the
  // oldest FIFO entry on data_o/out_*.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/bin_select_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Plain single-clock storage FIFO with a synchronous clear. Exposes both the
// entry at the read pointer and the one after it so the consumer can refill a
// registered head stage back-to-back.
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : synchronous clear (pointers and level to 0)
//   wr_en_i/wdata_i : push (ignored when full)
//   rd_en_i       : pop (ignored when empty)
//   rdata_o       : entry at read pointer
//   rdata_nxt_o   : entry at read pointer + 1
//   level_o       : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import bin_select_fifo_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rdata_o,
  output logic [W-1:0]             rdata_nxt_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_ok, rd_ok;

  assign wr_ok = wr_en_i && (level_q != FULL);
  assign rd_ok = rd_en_i && (level_q != '0);

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; level gates what is ever read out.
  always_ff @(posedge clk) begin
    if (!rst && !clr_i && wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign rdata_nxt_o = mem_q[rd_ptr_q + AW'(1)];
  assign level_o     = level_q;

endmodule

// File: rtl/bin_select_fifo.sv
// -----------------------------------------------------------------------------
// bin_select_fifo
// Keeps FFT bins BIN_LO..BIN_HI from a stream, converts the sample width
// (sign-extend or saturate), buffers {data, rebased idx, frame} in a FIFO and
// presents the oldest entry through a registered head stage with valid/ready.
//   clk, rst                  : clock, synchronous active-high reset
//   di_en, data_i             : input sample valid / signed sample (no backpressure)
//   in_group_idx, in_group_num: bin index and frame number of data_i
//   flush                     : synchronous clear of buffered content
//   do_rdy / do_en            : downstream ready / output valid
//   data_o, out_group_idx,
//   out_group_num             : head entry (idx rebased to BIN_LO)
//   frame_last                : head is the last kept bin of a frame
//   overflow                  : sticky, a kept sample was dropped on full
//   level                     : FIFO occupancy, head entry included
// -----------------------------------------------------------------------------
module bin_select_fifo
  import bin_select_fifo_pkg::*;
#(
  parameter int I_BW   = DEF_I_BW,
  parameter int O_BW   = DEF_O_BW,
  parameter int LOG2_N = DEF_LOG2_N,
  parameter int BIN_LO = DEF_BIN_LO,
  parameter int BIN_HI = DEF_BIN_HI,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FRM_BW = DEF_FRM_BW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      di_en,
  input  logic signed [I_BW-1:0]    data_i,
  input  logic [LOG2_N-1:0]         in_group_idx,
  input  logic [FRM_BW-1:0]         in_group_num,
  input  logic                      flush,
  input  logic                      do_rdy,
  output logic                      do_en,
  output logic signed [O_BW-1:0]    data_o,
  output logic [LOG2_N-1:0]         out_group_idx,
  output logic [FRM_BW-1:0]         out_group_num,
  output logic                      frame_last,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = O_BW + LOG2_N + FRM_BW;
  localparam logic [LOG2_N-1:0] LO_IDX   = LOG2_N'(BIN_LO);
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(BIN_HI - BIN_LO);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Bin selection
  // ---------------------------------------------------------------------------
  int   idx_int;
  logic keep, full, push, pop;

  // Compare as int so a zero BIN_LO does not degenerate into an unsigned
  // always-true comparison.
  assign idx_int = int'(in_group_idx);
  assign keep    = di_en && (idx_int >= BIN_LO) && (idx_int <= BIN_HI);
  assign full    = (level == FULL_LVL);
  // A full FIFO drops even when the head is popped on the same edge.
  assign push    = keep && !flush && !full;

  // ---------------------------------------------------------------------------
  // Width conversion
  // ---------------------------------------------------------------------------
  logic signed [O_BW-1:0] conv;

  if (O_BW >= I_BW) begin : g_ext
    assign conv = O_BW'(data_i);
  end else begin : g_sat
    localparam logic signed [I_BW-1:0] SAT_MAX = I_BW'((2 ** (O_BW-1)) - 1);
    localparam logic signed [I_BW-1:0] SAT_MIN = I_BW'(-(2 ** (O_BW-1)));
    always_comb begin
      if (data_i > SAT_MAX)      conv = SAT_MAX[O_BW-1:0];
      else if (data_i < SAT_MIN) conv = SAT_MIN[O_BW-1:0];
      else                       conv = data_i[O_BW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] wdata, rd_cur, rd_nxt;

  assign wdata = {conv, in_group_idx - LO_IDX, in_group_num};

  sync_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush),
    .wr_en_i     (push),
    .wdata_i     (wdata),
    .rd_en_i     (pop),
    .rdata_o     (rd_cur),
    .rdata_nxt_o (rd_nxt),
    .level_o     (level)
  );

  // ---------------------------------------------------------------------------
  // Head register FSM
  // The head is a registered copy of the FIFO entry at the read pointer; the
  // entry stays counted in level until it is transferred.
  // ---------------------------------------------------------------------------
  out_state_e       state_q, state_d;
  logic [ENT_W-1:0] head_q;
  logic             load_cur, load_nxt;
  logic             ovf_q, ovf_d;

  assign pop   = (state_q == ST_VALID) && do_rdy;
  assign ovf_d = ovf_q | (keep && !flush && full);

  always_comb begin
    state_d  = state_q;
    load_cur = 1'b0;
    load_nxt = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (level != '0) begin
            state_d  = ST_VALID;
            load_cur = 1'b1;
          end
        end
        ST_VALID: begin
          // On pop, only entries already stored before this edge can refill
          // the head; a same-cycle push is picked up one edge later.
          if (do_rdy) begin
            if (level > LVL_W'(1)) load_nxt = 1'b1;
            else                   state_d  = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      if (load_cur)      head_q <= rd_cur;
      else if (load_nxt) head_q <= rd_nxt;
    end
  end

  assign do_en         = (state_q == ST_VALID);
  assign data_o        = $signed(head_q[ENT_W-1 -: O_BW]);
  assign out_group_idx = head_q[FRM_BW +: LOG2_N];
  assign out_group_num = head_q[FRM_BW-1:0];
  assign frame_last    = do_en && (out_group_idx == LAST_IDX);
  assign overflow      = ovf_q;

endmodule

// File: doc/bin_select_fifo.md
BIN_SELECT_FIFO -- requirements
Module: bin_select_fifo

Interface
REQ-001 SHALL have parameter I_BW, default 14, input sample width (signed).
REQ-002 SHALL have parameter O_BW, default 14, output sample width (signed).
REQ-003 SHALL have parameter LOG2_N, default 10, FFT bin index width (N = 2**LOG2_N).
REQ-004 SHALL have parameter BIN_LO, default 0, first kept bin (inclusive).
REQ-005 SHALL have parameter BIN_HI, default 512, last kept bin (inclusive); 0 <= BIN_LO <= BIN_HI < N.
REQ-006 SHALL have parameter DEPTH, default 16, FIFO depth in entries (power of 2, >= 2).
REQ-007 SHALL have parameter FRM_BW, default 7, frame number width.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous and active-high.
REQ-010 di_en  in  1  input sample valid; no backpressure on input side.
REQ-011 data_i  in  I_BW  signed input sample.
REQ-012 in_group_idx  in  LOG2_N  bin index of data_i.
REQ-013 in_group_num  in  FRM_BW  frame number of data_i.
REQ-014 flush  in  1  synchronous FIFO clear.
REQ-015 do_rdy  in  1  downstream ready.
REQ-016 do_en  out  1  output valid.
REQ-017 data_o  out  O_BW  signed output sample.
REQ-018 out_group_idx  out  LOG2_N  re-based bin index (in_group_idx - BIN_LO).
REQ-019 out_group_num  out  FRM_BW  frame number carried with sample.
REQ-020 frame_last  out  1  high with do_en when out_group_idx == BIN_HI - BIN_LO.
REQ-021 overflow  out  1  sticky: a kept sample was dropped.
REQ-022 level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-023 Sample kept iff di_en=1 and BIN_LO <= in_group_idx <= BIN_HI; otherwise discarded, no state change.
REQ-024 Kept sample written as {converted data, idx - BIN_LO, in_group_num} when level < DEPTH; when level == DEPTH it is dropped and overflow set, even if a pop occurs the same cycle.
REQ-025 Width rule: O_BW >= I_BW sign-extend; O_BW < I_BW saturate to [-2**(O_BW-1), 2**(O_BW-1)-1].
REQ-026 Output is a head register, not fall-through: sample written at edge k is first visible with do_en=1 after edge k+1 when the FIFO was empty.
REQ-027 Transfer occurs on an edge where do_en=1 and do_rdy=1; data_o/out_* hold stable while do_en=1 and do_rdy=0.
REQ-028 Simultaneous push and pop with 0 < level < DEPTH: level unchanged, ordering preserved.
REQ-029 Pointers wrap modulo DEPTH; level never exceeds DEPTH or goes below 0.
REQ-030 frame_last is combinationally qualified by do_en; it is never high while do_en=0.
REQ-031 flush=1: next edge level=0, do_en=0, pointers=0; concurrent kept input is dropped without setting overflow; overflow retains its value.
REQ-032 Output state machine: EMPTY (do_en=0) -> VALID on head load; VALID -> EMPTY on pop with no further data; VALID -> VALID on pop with data available (back-to-back, one sample/cycle).
REQ-033 overflow clears only on rst.

Reset
REQ-034 On rst=1 at an edge: do_en=0, data_o=0, out_group_idx=0, out_group_num=0, overflow=0, level=0, pointers=0, state EMPTY.
REQ-035 rst mid-stream discards all FIFO content; rst has priority over flush and di_en.

Structure
REQ-036 Shared package SHALL hold default widths (I_BW, O_BW, LOG2_N, FRM_BW) and the default kept range (BIN_LO=0, BIN_HI=N/2).
REQ-037 A single sub-module sync_fifo (parameterised width/depth, synchronous active-high reset, clear input) SHALL hold storage; selection, conversion and head register stay in bin_select_fifo.

Verification
REQ-038 Frame of bins 0..1023, do_rdy=1, defaults -> exactly 513 outputs, idx 0..512 in order, frame_last only on idx 512, overflow=0.
REQ-039 BIN_LO=5, BIN_HI=9, bins 0..15 -> 5 outputs, out_group_idx 0..4, data unchanged.
REQ-040 DEPTH=4, do_rdy=0, 6 kept samples -> level=4, overflow=1 after 5th; do_rdy=1 releases first 4 in order.
REQ-041 I_BW=16, O_BW=14, data_i=20000 and -20000 -> data_o=8191 and -8192.
REQ-042 level=3, flush and kept di_en in same cycle -> next cycle level=0, do_en=0, overflow unchanged.
REQ-043 rst asserted with level=5, do_en=1 -> next cycle all outputs 0; first kept sample afterwards appears after 2 edges.
